// File: rtl/audio_pkg.sv
// Shared audio definitions used by the tone player, the averaging filter and
// the top level.
package audio_pkg;

  localparam int SAMPLE_W      = 24;
  localparam int DEFAULT_LOG2N = 3;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/audio_avg_filter_if.sv
// Sample stream into the averaging filter and the filtered stream out of it.
interface audio_avg_filter_if
  import audio_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
);

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     primed;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  primed
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output primed
  );

endinterface

// File: rtl/sample_ring.sv
// N-entry circular buffer: presents the oldest entry combinationally and
// replaces it with the new value on each write.
module sample_ring
  import audio_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int LOG2N  = DEFAULT_LOG2N
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wrEn,
  input  logic signed [DATA_W-1:0] i_wrData,
  output logic signed [DATA_W-1:0] o_oldest,
  output logic [LOG2N-1:0]         o_wptr
);

  localparam int N = 1 << LOG2N;

  logic signed [DATA_W-1:0] r_entries [N];
  logic [LOG2N-1:0]         r_wptr;

  assign o_oldest = r_entries[r_wptr];
  assign o_wptr   = r_wptr;

  // N is a power of two, so the pointer wraps N-1 -> 0 by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_entries[i] <= '0;
      end
      r_wptr <= '0;
    end else if (i_wrEn) begin
      r_entries[r_wptr] <= i_wrData;
      r_wptr            <= r_wptr + 1'b1;
    end
  end

endmodule

// File: rtl/audio_avg_filter.sv
// Single-channel moving-average filter: running sum of the last N pre-scaled
// samples, so the sum itself is the average.
module audio_avg_filter
  import audio_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int LOG2N  = DEFAULT_LOG2N
) (
  input  logic              clk,
  input  logic              reset,
  audio_avg_filter_if.slave bus
);

  localparam int                N     = 1 << LOG2N;
  localparam int                CNT_W = LOG2N + 1;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(N);

  logic signed [DATA_W-1:0] w_scaled;
  logic signed [DATA_W-1:0] w_oldest;
  logic signed [DATA_W-1:0] w_accNext;
  logic [LOG2N-1:0]         w_wptr;

  logic signed [DATA_W-1:0] r_acc;
  logic signed [DATA_W-1:0] r_outData;
  logic                     r_outValid;
  logic                     r_primed;
  logic [CNT_W-1:0]         r_fillCount;

  // Pre-scaling each entry keeps the N-entry sum inside DATA_W.
  assign w_scaled  = bus.in_data >>> LOG2N;
  assign w_accNext = r_acc + w_scaled - w_oldest;

  sample_ring #(
    .DATA_W(DATA_W),
    .LOG2N (LOG2N)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .i_wrEn  (bus.in_valid),
    .i_wrData(w_scaled),
    .o_oldest(w_oldest),
    .o_wptr  (w_wptr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_outData   <= '0;
      r_outValid  <= 1'b0;
      r_primed    <= 1'b0;
      r_fillCount <= '0;
    end else begin
      r_outValid <= bus.in_valid;
      if (bus.in_valid) begin
        r_acc     <= w_accNext;
        r_outData <= w_accNext;
        if (r_fillCount != FULL) begin
          r_fillCount <= r_fillCount + 1'b1;
        end
        // Rise together with the out_valid of the Nth sample.
        if (r_fillCount == FULL - 1'b1) begin
          r_primed <= 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;
  assign bus.primed    = r_primed;

endmodule

// File: tb/tb_audio_avg_filter.sv
// Scoreboard bench for audio_avg_filter: directed samples push hand-computed
// averages, a negedge monitor pops and compares whenever out_valid is seen.
module tb_audio_avg_filter;
  import audio_pkg::*;

  typedef struct {
    int  data;
    logic primed;
    int  due;
  } exp_t;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;
  int   cycleCount;
  int   lastOut;
  logic lastPrimed;
  exp_t sbQ[$];

  audio_avg_filter_if #(.DATA_W(SAMPLE_W)) bus ();

  audio_avg_filter #(
    .DATA_W(SAMPLE_W),
    .LOG2N (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d (0x%06h), expected %0d (0x%06h) at cycle %0d",
               name, actual, actual[23:0], expected, expected[23:0], cycleCount);
    end
  endtask

  // Drive one sample for one cycle and queue its expected response.
  task automatic applyStimulus(input int data, input int expected, input logic expPrimed);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = data[23:0];
    e.data   = expected;
    e.primed = expPrimed;
    e.due    = cycleCount + 1;
    sbQ.push_back(e);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
    end
  endtask

  task automatic doReset();
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset out_data", int'(bus.out_data), 0);
    checkOutput("reset out_valid", int'(bus.out_valid), 0);
    checkOutput("reset primed", int'(bus.primed), 0);
    reset      = 1'b0;
    lastOut    = 0;
    lastPrimed = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) begin
        if (sbQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected out_valid: got 1, expected 0 at cycle %0d", cycleCount);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("out_data", int'(bus.out_data), e.data);
          checkOutput("primed", int'(bus.primed), int'(e.primed));
          checkOutput("latency cycle", cycleCount, e.due);
        end
        lastOut    = int'(bus.out_data);
        lastPrimed = bus.primed;
      end else begin
        if (sbQ.size() > 0 && sbQ[0].due <= cycleCount) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL missing out_valid: got 0, expected 1 (data %0d) at cycle %0d",
                   sbQ[0].data, cycleCount);
          void'(sbQ.pop_front());
        end
        checkOutput("held out_data", int'(bus.out_data), lastOut);
        checkOutput("held primed", int'(bus.primed), int'(lastPrimed));
      end
    end
  end

  initial begin
    int full;
    int neg;
    int descent [8];
    testsRun     = 0;
    testsFailed  = 0;
    cycleCount   = 0;
    lastOut      = 0;
    lastPrimed   = 1'b0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #12;
    doReset();

    for (int k = 1; k <= 8; k++) applyStimulus(800, 100 * k, k == 8);
    for (int k = 1; k <= 8; k++) applyStimulus(0, 800 - 100 * k, 1'b1);

    doReset();
    for (int k = 1; k <= 8; k++) applyStimulus(-8, -k, k == 8);
    for (int k = 1; k <= 8; k++) applyStimulus(7, -8 + k, 1'b1);

    doReset();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(800, 100 * k, k == 8);
      idle(2);
    end

    doReset();
    for (int k = 1; k <= 5; k++) applyStimulus(800, 100 * k, 1'b0);
    idle(2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset out_data", int'(bus.out_data), 0);
    checkOutput("async reset primed", int'(bus.primed), 0);
    checkOutput("async reset out_valid", int'(bus.out_valid), 0);
    lastOut    = 0;
    lastPrimed = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(800, 100, 1'b0);
    applyStimulus(800, 200, 1'b0);

    doReset();
    full = 32'h007F_FFFF;
    neg  = -8388608;
    for (int k = 1; k <= 8; k++) applyStimulus(full, 1048575 * k, k == 8);
    descent = '{6291449, 4194298, 2097147, -4, -2097155, -4194306, -6291457, -8388608};
    for (int k = 0; k < 8; k++) applyStimulus(neg, descent[k], 1'b1);

    idle(1);
    for (int i = 0; i < 10 && sbQ.size() > 0; i++) idle(1);
    if (sbQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending outputs, expected 0", sbQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
